mem_access_initiator: RTL and testbench

- Initiator (CPU-side) end of the main memory bus: accepts one memory-reference request per transaction from the PDP-8 control unit.
- Forms the effective address from page/offset fields and performs an indirect pointer read, with auto-index increment and write-back when needed.
- Then issues the final data read or write, or an instruction fetch, using the read/write-enable / mem_finished handshake that the memory controller responds to.
- Returns data and the effective address to the CPU with a one-cycle done pulse.

---
 rtl/mem_access_initiator_pkg.sv | 34 +++
 rtl/mem_access_initiator_ea_former.sv | 23 ++
 rtl/mem_access_initiator.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_initiator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_initiator_pkg.sv
// Shared types for the CPU-side memory-bus initiator.
// Pure declarations; no logic or latency.
// No flow control of its own.
package mem_access_initiator_pkg;

   typedef logic [11:0] word;

   // Bus read qualifier; DATA_READ is the idle/reset encoding.
   typedef enum logic {
      DATA_READ         = 1'b0,
      INSTRUCTION_FETCH = 1'b1
   } read_type_t;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      READ    = 2'b01,
      WRITE   = 2'b10,
      EA_ONLY = 2'b11
   } mem_op_t;

   // Prefixed so they cannot collide with the read_type_t literals.
   typedef enum logic [2:0] {
      S_IDLE,
      S_IND_READ,
      S_AUTO_WRITE,
      S_DATA_READ,
      S_DATA_WRITE,
      S_COMPLETE
   } init_states;

   localparam word AUTO_LO_DEF = 12'o0010;
   localparam word AUTO_HI_DEF = 12'o0017;

endpackage

// File: rtl/mem_access_initiator_ea_former.sv
// Direct effective address from Z bit / page / offset, plus auto-index range detect.
// Purely combinational, zero latency.
// No backpressure.
module mem_access_initiator_ea_former
   import mem_access_initiator_pkg::*;
#(
   parameter word AUTO_LO = AUTO_LO_DEF,
   parameter word AUTO_HI = AUTO_HI_DEF
) (
   input  logic       cur_page,
   input  logic [4:0] pc_page,
   input  logic [6:0] offset,
   output word        dir_addr,
   output logic       in_auto
);

   // Full 12-bit compare: a current-page address only qualifies when pc_page is zero.
   always_comb begin
      dir_addr = cur_page ? {pc_page, offset} : {5'b0, offset};
      in_auto  = (dir_addr >= AUTO_LO) && (dir_addr <= AUTO_HI);
   end

endmodule

// File: rtl/mem_access_initiator.sv
// Memory-reference initiator: EA forming, indirect/auto-index pointer handling, final access.
// Each bus access lasts until mem_finished; done pulses one cycle after the last access.
// req is only sampled in IDLE; bus enables hold until the responder signals mem_finished.
module mem_access_initiator
   import mem_access_initiator_pkg::*;
#(
   parameter word AUTO_LO = AUTO_LO_DEF,
   parameter word AUTO_HI = AUTO_HI_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic        indirect,
   input  logic        cur_page,
   input  logic [6:0]  offset,
   input  logic [11:0] pc,
   input  logic [11:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [11:0] rdata,
   output logic [11:0] eff_addr,
   output logic        read_type,
   output logic [11:0] mem_address,
   output logic [11:0] mem_write_data,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   input  logic [11:0] mem_read_data,
   input  logic        mem_finished
);

   init_states state_q, state_d;
   mem_op_t    op_q, op_d, op_now;
   word        dir_q, dir_d, wlat_q, wlat_d, wd_now;
   word        addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d, eff_q, eff_d;
   logic       auto_q, auto_d, re_q, re_d, we_q, we_d;
   read_type_t rt_q, rt_d;
   word        dir_addr, fin_addr, ptr_inc;
   logic       in_auto, go_final;

   mem_access_initiator_ea_former #(.AUTO_LO(AUTO_LO), .AUTO_HI(AUTO_HI)) u_ea (
      .cur_page (cur_page),
      .pc_page  (pc[11:7]),
      .offset   (offset),
      .dir_addr (dir_addr),
      .in_auto  (in_auto)
   );

   assign ptr_inc = mem_read_data + 12'd1;

   // Next state and registered bus outputs; go_final funnels every path into the last access.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dir_d    = dir_q;
      auto_d   = auto_q;
      wlat_d   = wlat_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      re_d     = re_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      eff_d    = eff_q;
      rt_d     = rt_q;
      go_final = 1'b0;
      fin_addr = addr_q;
      op_now   = op_q;
      wd_now   = wlat_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_now = mem_op_t'(op);
               wd_now = wdata;
               op_d   = op_now;
               dir_d  = dir_addr;
               auto_d = in_auto;
               wlat_d = wdata;
               if (op_now == FETCH) begin
                  state_d = S_DATA_READ;
                  addr_d  = pc;
                  re_d    = 1'b1;
                  eff_d   = pc;
                  rt_d    = INSTRUCTION_FETCH;
               end else begin
                  rt_d = DATA_READ;
                  if (indirect) begin
                     state_d = S_IND_READ;
                     addr_d  = dir_addr;
                     re_d    = 1'b1;
                  end else begin
                     go_final = 1'b1;
                     fin_addr = dir_addr;
                  end
               end
            end
         end
         S_IND_READ: begin
            if (mem_finished) begin
               re_d = 1'b0;
               if (auto_q) begin
                  state_d = S_AUTO_WRITE;
                  addr_d  = dir_q;
                  wd_d    = ptr_inc;
                  we_d    = 1'b1;
               end else begin
                  go_final = 1'b1;
                  fin_addr = mem_read_data;
               end
            end
         end
         S_AUTO_WRITE: begin
            // The incremented pointer is still sitting in the write-data register.
            if (mem_finished) begin
               we_d     = 1'b0;
               go_final = 1'b1;
               fin_addr = wd_q;
            end
         end
         S_DATA_READ: begin
            if (mem_finished) begin
               re_d    = 1'b0;
               rdata_d = mem_read_data;
               state_d = S_COMPLETE;
            end
         end
         S_DATA_WRITE: begin
            if (mem_finished) begin
               we_d    = 1'b0;
               state_d = S_COMPLETE;
            end
         end
         S_COMPLETE: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (go_final) begin
         eff_d = fin_addr;
         case (op_now)
            READ: begin
               state_d = S_DATA_READ;
               addr_d  = fin_addr;
               re_d    = 1'b1;
            end
            WRITE: begin
               state_d = S_DATA_WRITE;
               addr_d  = fin_addr;
               wd_d    = wd_now;
               we_d    = 1'b1;
            end
            default: state_d = S_COMPLETE;
         endcase
      end
   end

   // State and output registers; reset drops the enables immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= FETCH;
         dir_q   <= '0;
         auto_q  <= 1'b0;
         wlat_q  <= '0;
         addr_q  <= '0;
         wd_q    <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         eff_q   <= '0;
         rt_q    <= DATA_READ;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dir_q   <= dir_d;
         auto_q  <= auto_d;
         wlat_q  <= wlat_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         re_q    <= re_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         eff_q   <= eff_d;
         rt_q    <= rt_d;
      end
   end

   assign busy             = (state_q != S_IDLE);
   assign done             = (state_q == S_COMPLETE);
   assign rdata            = rdata_q;
   assign eff_addr         = eff_q;
   assign read_type        = rt_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = wd_q;
   assign mem_read_enable  = re_q;
   assign mem_write_enable = we_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
module tb_mem_access_initiator;
   import mem_access_initiator_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        indirect = 1'b0, cur_page = 1'b0;
   logic [6:0]  offset = '0;
   logic [11:0] pc = '0, wdata = '0;
   logic        busy, done, read_type, mem_read_enable, mem_write_enable, mem_finished;
   logic [11:0] rdata, eff_addr, mem_address, mem_write_data, mem_read_data;

   mem_access_initiator dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .indirect(indirect),
      .cur_page(cur_page), .offset(offset), .pc(pc), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .eff_addr(eff_addr),
      .read_type(read_type), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_read_data(mem_read_data), .mem_finished(mem_finished)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus responder + memory: finished in the third cycle of each enable.
   logic [11:0] mem [4096];
   logic [11:0] ref_mem [4096];
   logic        fin;
   int          cnt;
   logic        poke_en = 1'b0, fill_en = 1'b0;
   logic [11:0] poke_a = '0, poke_d = '0;

   function automatic logic [11:0] init_val(int i);
      return 12'(i * 1373 + (i >> 4) * 7 + 99);
   endfunction

   assign mem_read_data = mem[mem_address];
   assign mem_finished  = fin;

   always @(posedge clk or negedge rst_n) begin
      if (fill_en) for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      if (poke_en) mem[poke_a] <= poke_d;
      if (!rst_n) begin
         fin <= 1'b0;
         cnt <= 0;
      end else if (fin) begin
         fin <= 1'b0;
         cnt <= 0;
         if (mem_write_enable) mem[mem_address] <= mem_write_data;
      end else if (mem_read_enable || mem_write_enable) begin
         if (cnt == 1) fin <= 1'b1;
         else cnt <= cnt + 1;
      end
   end

   typedef struct {
      logic [11:0] ea;
      logic [11:0] rd;
      logic        rt;
      int          due;
   } exp_t;
   exp_t        sb[$];
   int          checks = 0, errors = 0, en_cycles = 0;
   logic [11:0] last_rd = '0;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %o expected %o (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [11:0] d);
      ref_mem[a] = d;
      poke_a = a; poke_d = d; poke_en = 1'b1;
      @(posedge clk); #1 poke_en = 1'b0;
      @(negedge clk);
   endtask

   // Reference: walk the addressing rules directly on a shadow memory.
   task automatic model(input logic [1:0] o, input logic ind, input logic cp,
                        input logic [6:0] off, input logic [11:0] p, input logic [11:0] w,
                        output exp_t e);
      int d, ptr, lat;
      e.rt = 1'b0;
      if (o == 2'b00) begin
         e.ea = p; e.rd = ref_mem[p]; e.rt = 1'b1; lat = 4;
         last_rd = e.rd;
      end else begin
         d = cp ? (int'(p) / 128) * 128 + int'(off) : int'(off);
         lat = 1;
         ptr = d;
         if (ind) begin
            ptr = int'(ref_mem[d]);
            lat += 3;
            if (d >= 8 && d <= 15) begin
               ptr = (ptr + 1) % 4096;
               ref_mem[d] = 12'(ptr);
               lat += 3;
            end
         end
         e.ea = 12'(ptr);
         if (o == 2'b01) begin
            last_rd = ref_mem[ptr]; lat += 3;
         end else if (o == 2'b10) begin
            ref_mem[ptr] = w; lat += 3;
         end
         e.rd = last_rd;
      end
      e.due = lat;
   endtask

   task automatic finish_now();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      if (busy) begin
         errors++;
         $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
         finish_now();
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic ind, input logic cp,
                        input logic [6:0] off, input logic [11:0] p, input logic [11:0] w,
                        input bit pulse);
      exp_t e;
      wait_idle();
      model(o, ind, cp, off, p, w, e);
      e.due += cyc;
      sb.push_back(e);
      op = o; indirect = ind; cur_page = cp; offset = off; pc = p; wdata = w; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      // Scramble operands: the DUT must be using its latched copies.
      op = 2'($urandom); indirect = 1'($urandom); cur_page = 1'($urandom);
      offset = 7'($urandom); pc = 12'($urandom); wdata = 12'($urandom);
      if (pulse) begin
         @(negedge clk);
         if (busy) begin
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
         end
      end
   endtask

   task automatic monitor();
      logic        prev_en = 1'b0, prev_fin = 1'b0;
      logic [11:0] prev_a = '0, prev_w = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_en = 1'b0;
         end else begin
            if (mem_read_enable && mem_write_enable)
               chk("both_enables", 12'd1, 12'd0);
            if (mem_read_enable || mem_write_enable) begin
               en_cycles++;
               if (prev_en && !prev_fin) begin
                  chk("addr_stable", mem_address, prev_a);
                  chk("wdata_stable", mem_write_data, prev_w);
               end
            end
            prev_en  = mem_read_enable || mem_write_enable;
            prev_fin = mem_finished;
            prev_a   = mem_address;
            prev_w   = mem_write_data;
            if (done) begin
               if (sb.size() == 0) begin
                  chk("spurious_done", 12'd1, 12'd0);
               end else begin
                  e = sb.pop_front();
                  chk("eff_addr", eff_addr, e.ea);
                  chk("rdata", rdata, e.rd);
                  chk("read_type", {11'd0, read_type}, {11'd0, e.rt});
                  chk("done_cycle", 12'(cyc), 12'(e.due));
               end
            end
         end
      end
   endtask

   task automatic stimulus();
      int e0, n, diffs;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      fill_en = 1'b1;
      @(posedge clk); #1 fill_en = 1'b0;
      @(negedge clk);
      chk("rst_busy", {11'd0, busy}, 12'd0);
      chk("rst_done", {11'd0, done}, 12'd0);
      chk("rst_rdata", rdata, 12'd0);
      chk("rst_eff", eff_addr, 12'd0);
      chk("rst_rtype", {11'd0, read_type}, 12'd0);
      chk("rst_addr", mem_address, 12'd0);
      chk("rst_wdat", mem_write_data, 12'd0);
      chk("rst_en", {10'd0, mem_read_enable, mem_write_enable}, 12'd0);
      rst_n = 1'b1;
      @(negedge clk);

      poke(12'o0200, 12'o7300);
      issue(2'b00, 1'b1, 1'b1, 7'o55, 12'o0200, 12'o0, 1'b0);
      poke(12'o1205, 12'o4321);
      issue(2'b01, 1'b0, 1'b1, 7'o05, 12'o1234, 12'o0, 1'b1);
      wait_idle();
      poke(12'o0020, 12'o3000);
      issue(2'b10, 1'b1, 1'b0, 7'o20, 12'o1234, 12'o0777, 1'b1);
      wait_idle();
      chk("ind_write_target", mem[12'o3000], 12'o0777);
      chk("ind_write_ptr", mem[12'o0020], 12'o3000);
      poke(12'o0010, 12'o7777);
      poke(12'o0000, 12'o0055);
      issue(2'b01, 1'b1, 1'b0, 7'o10, 12'o4400, 12'o0, 1'b0);
      wait_idle();
      chk("auto_wrap", mem[12'o0010], 12'o0000);
      e0 = en_cycles;
      issue(2'b11, 1'b0, 1'b0, 7'o17, 12'o0, 12'o0, 1'b0);
      wait_idle();
      chk("ea_direct_no_bus", 12'(en_cycles - e0), 12'd0);
      poke(12'o0017, 12'o0100);
      e0 = en_cycles;
      issue(2'b11, 1'b1, 1'b0, 7'o17, 12'o0, 12'o0, 1'b1);
      wait_idle();
      chk("ea_ind_ptr", mem[12'o0017], 12'o0101);
      chk("ea_ind_bus_cycles", 12'(en_cycles - e0), 12'd6);
      // Current-page alias of 0010 with a non-zero page must not auto-index.
      poke(12'o0210, 12'o0500);
      issue(2'b01, 1'b1, 1'b1, 7'o10, 12'o0200, 12'o0, 1'b0);
      wait_idle();
      chk("cur_page_no_auto", mem[12'o0210], 12'o0500);

      // Reset in the middle of a direct WRITE; nothing is expected from it.
      op = 2'b10; indirect = 1'b0; cur_page = 1'b0; offset = 7'o33; wdata = 12'o1111; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!mem_write_enable && n < 20) begin @(negedge clk); n++; end
      chk("mid_write_enable", {11'd0, mem_write_enable}, 12'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", {10'd0, mem_read_enable, mem_write_enable}, 12'd0);
      chk("mid_rst_busy", {10'd0, busy, done}, 12'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
      @(negedge clk);
      issue(2'b01, 1'b0, 1'b0, 7'o33, 12'o0, 12'o0, 1'b1);

      for (int t = 0; t < 200; t++) begin
         logic [11:0] p;
         logic [6:0]  off;
         p   = ($urandom_range(0, 3) == 0) ? {5'd0, 7'($urandom)} : 12'($urandom);
         off = ($urandom_range(0, 2) == 0) ? 7'(8 + $urandom_range(0, 7)) : 7'($urandom);
         issue(2'($urandom), 1'($urandom), 1'($urandom), off, p, 12'($urandom),
               1'($urandom));
      end
      wait_idle();
      repeat (2) @(negedge clk);
      chk("sb_drained", 12'(sb.size()), 12'd0);
      diffs = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image_diffs", 12'(diffs), 12'd0);
   endtask

   initial begin
      fork
         monitor();
      join_none
      stimulus();
      disable fork;
      finish_now();
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
      finish_now();
   end

endmodule
